hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
- Control block for the EX-stage ALU operand muxes in the 5-stage pipeline.
- Generates the forwarda/forwardb select codes the operand muxes consume.
- Detects load-use hazards and sequences multi-cycle mul/div occupancy of EX through a small FSM.
- Drives pipeline stall/flush controls and keeps a saturating stall-cycle performance counter.

Parameters:
REG_ADDR_WIDTH, 5, register index width
MULDIV_LATENCY, 4, total EX cycles a mul/div occupies (>=1)
PERF_WIDTH, 16, width of stall-cycle counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
rs1_id  input  REG_ADDR_WIDTH  source 1 of instruction in ID
rs2_id  input  REG_ADDR_WIDTH  source 2 of instruction in ID
rs1_used_id  input  1  ID instruction reads rs1
rs2_used_id  input  1  ID instruction reads rs2
rs1_ex  input  REG_ADDR_WIDTH  source 1 of instruction in EX
rs2_ex  input  REG_ADDR_WIDTH  source 2 of instruction in EX
rd_ex  input  REG_ADDR_WIDTH  destination of EX instruction
regwrite_ex  input  1  EX instruction writes rd
memread_ex  input  1  EX instruction is a load
muldiv_start_ex  input  1  EX instruction is mul/div (valid in its first EX cycle)
rd_mem  input  REG_ADDR_WIDTH  destination in MEM
regwrite_mem  input  1  MEM instruction writes rd
rd_wb  input  REG_ADDR_WIDTH  destination in WB
regwrite_wb  input  1  WB instruction writes rd
forwarda  output  2  operand-1 select: 00 regfile, 10 MEM, 01 WB
forwardb  output  2  operand-2 select, same encoding
stall_if  output  1  hold PC
stall_id  output  1  hold IF/ID register
stall_ex  output  1  hold ID/EX register and EX operands
flush_ex  output  1  insert bubble into ID/EX next edge
muldiv_done  output  1  mul/div result valid this cycle
stall_cycles  output  PERF_WIDTH  saturating count of cycles with stall_if=1

Behaviour:
- Reset (rst=0, async): state=RUN, cnt=0, stall_cycles=0. All 1-bit outputs are forced to 0 and forwarda/forwardb are forced to 00 while rst=0.
- Forwarding (combinational, state RUN):
  - forwarda=10 if regwrite_mem && rd_mem!=0 && rd_mem==rs1_ex.
  - Else forwarda=01 if regwrite_wb && rd_wb!=0 && rd_wb==rs1_ex.
  - Else forwarda=00.
  - MEM has priority over WB. forwardb is identical using rs2_ex. Code 11 is never produced. x0 is never forwarded.
- Load-use (combinational, state RUN, muldiv_start_ex=0):
  - hazard = memread_ex && regwrite_ex && rd_ex!=0 && ((rs1_used_id && rs1_id==rd_ex) || (rs2_used_id && rs2_id==rd_ex)).
  - hazard drives stall_if=stall_id=flush_ex=1 for exactly that cycle, with stall_ex=0.
  - The following cycle has a bubble in EX, so no re-detection. Total penalty is 1 cycle.
- FSM states RUN, BUSY; cnt is ceil(log2(MULDIV_LATENCY))+1 bits.
  - RUN, muldiv_start_ex=1, MULDIV_LATENCY=1: muldiv_done=1 that cycle, no stalls, stay RUN.
  - RUN, muldiv_start_ex=1, MULDIV_LATENCY>1: stall_if=stall_id=stall_ex=1, flush_ex=0. Load cnt=MULDIV_LATENCY-1 and go to BUSY.
  - BUSY, cnt>1: stalls asserted, cnt decrements.
  - BUSY, cnt==1: muldiv_done=1, stalls deasserted, cnt set to 0, go to RUN.
  - EX occupancy is exactly MULDIV_LATENCY cycles, with stalls in the first MULDIV_LATENCY-1 of them.
  - muldiv_start_ex is ignored in BUSY.
- Forward selects during BUSY are forced to 00. The mul/div unit captures its operands in the start cycle.
- Load-use detection is suppressed during BUSY and in the start cycle.
- muldiv_start_ex together with memread_ex is illegal; if it occurs, mul/div wins and flush_ex=0.
- stall_cycles increments on each clk edge where stall_if=1 and saturates at all-ones.
- Reset asserted mid-BUSY aborts immediately to RUN; there is no done pulse.

Test Plan:
- Forward priority: rs1_ex=5, rd_mem=5/regwrite_mem=1, rd_wb=5/regwrite_wb=1 -> forwarda=10. Drop regwrite_mem -> 01. Set rs1_ex=0 with rd=0 matches -> 00.
- Load-use: memread_ex=1, regwrite_ex=1, rd_ex=7, rs2_id=7, rs2_used_id=1 -> stall_if=stall_id=flush_ex=1 for 1 cycle; next cycle (memread_ex=0) all 0; stall_cycles=1. With rs2_used_id=0 -> no stall.
- Mul/div, MULDIV_LATENCY=4: muldiv_start_ex pulse -> stall_ex=1 for 3 cycles, muldiv_done=1 on cycle 4, then RUN; stall_cycles +3. Assert load-use inputs during BUSY -> flush_ex stays 0.
- MULDIV_LATENCY=1: muldiv_start_ex -> muldiv_done=1 same cycle, no stall, stall_cycles unchanged.
- Reset mid-BUSY: drop rst after 2 BUSY cycles -> outputs 0 asynchronously. Release -> RUN, stall_cycles=0, no muldiv_done.
- Saturation, PERF_WIDTH=4: 20 consecutive stall cycles -> stall_cycles=15 and holds.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_forward_ctrl : EX operand forwarding, load-use and mul/div stall control
// Revision: 1.0
// ============================================================================
module hazard_forward_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MULDIV_LATENCY = 4,
    parameter int PERF_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_id,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_id,
    input  logic                      rs1_used_id,
    input  logic                      rs2_used_id,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_ex,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_ex,
    input  logic [REG_ADDR_WIDTH-1:0] rd_ex,
    input  logic                      regwrite_ex,
    input  logic                      memread_ex,
    input  logic                      muldiv_start_ex,
    input  logic [REG_ADDR_WIDTH-1:0] rd_mem,
    input  logic                      regwrite_mem,
    input  logic [REG_ADDR_WIDTH-1:0] rd_wb,
    input  logic                      regwrite_wb,
    output logic [1:0]                forwarda,
    output logic [1:0]                forwardb,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      stall_ex,
    output logic                      flush_ex,
    output logic                      muldiv_done,
    output logic [PERF_WIDTH-1:0]     stall_cycles
);

    localparam int                 C_CNT_W    = $clog2(MULDIV_LATENCY) + 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(MULDIV_LATENCY - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [C_CNT_W-1:0]    r_cnt;
    logic [C_CNT_W-1:0]    w_cnt_nxt;
    logic [PERF_WIDTH-1:0] r_stall_cycles;
    logic [1:0]            w_fwd_a;
    logic [1:0]            w_fwd_b;
    logic                  w_hazard;

    // MEM result is newer than WB, so it wins; x0 is hard-wired and never forwarded.
    always_comb begin
        w_fwd_a = 2'b00;
        if (regwrite_mem && (rd_mem != '0) && (rd_mem == rs1_ex))
            w_fwd_a = 2'b10;
        else if (regwrite_wb && (rd_wb != '0) && (rd_wb == rs1_ex))
            w_fwd_a = 2'b01;
    end

    always_comb begin
        w_fwd_b = 2'b00;
        if (regwrite_mem && (rd_mem != '0) && (rd_mem == rs2_ex))
            w_fwd_b = 2'b10;
        else if (regwrite_wb && (rd_wb != '0) && (rd_wb == rs2_ex))
            w_fwd_b = 2'b01;
    end

    assign w_hazard = memread_ex && regwrite_ex && (rd_ex != '0) &&
                      ((rs1_used_id && (rs1_id == rd_ex)) ||
                       (rs2_used_id && (rs2_id == rd_ex)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        forwarda    = 2'b00;
        forwardb    = 2'b00;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        flush_ex    = 1'b0;
        muldiv_done = 1'b0;
        if (rst) begin
            case (r_state)
                ST_RUN: begin
                    forwarda = w_fwd_a;
                    forwardb = w_fwd_b;
                    // A mul/div start overrides any (illegal) concurrent load.
                    if (muldiv_start_ex) begin
                        if (MULDIV_LATENCY == 1) begin
                            muldiv_done = 1'b1;
                        end else begin
                            stall_if    = 1'b1;
                            stall_id    = 1'b1;
                            stall_ex    = 1'b1;
                            w_cnt_nxt   = C_CNT_LOAD;
                            w_state_nxt = ST_BUSY;
                        end
                    end else if (w_hazard) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt > C_CNT_ONE) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        w_cnt_nxt = r_cnt - C_CNT_ONE;
                    end else begin
                        muldiv_done = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cycles <= '0;
        else if (stall_if && (r_stall_cycles != {PERF_WIDTH{1'b1}}))
            r_stall_cycles <= r_stall_cycles + PERF_WIDTH'(1);
    end

    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_forward_ctrl : bench for three parameterisations sharing one stimulus
// Revision: 1.0
// ============================================================================
module tb_hazard_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic       rs1_used_id, rs2_used_id, regwrite_ex, memread_ex, muldiv_start_ex;
    logic       regwrite_mem, regwrite_wb;

    logic [1:0]  fa4, fb4, fa1, fb1, fas, fbs;
    logic        sif4, sid4, sex4, fex4, done4;
    logic        sif1, sid1, sex1, fex1, done1;
    logic        sifs, sids, sexs, fexs, dones;
    logic [15:0] sc4, sc1;
    logic [3:0]  scs;
    logic [8:0]  act4, act1, acts;

    int tests = 0;
    int fails = 0;

    int left4 = 0, left1 = 0;
    int cnt16 = 0, cnt1 = 0, cnt4 = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.REG_ADDR_WIDTH(5), .MULDIV_LATENCY(4), .PERF_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .regwrite_ex(regwrite_ex),
        .memread_ex(memread_ex), .muldiv_start_ex(muldiv_start_ex),
        .rd_mem(rd_mem), .regwrite_mem(regwrite_mem), .rd_wb(rd_wb), .regwrite_wb(regwrite_wb),
        .forwarda(fa4), .forwardb(fb4), .stall_if(sif4), .stall_id(sid4), .stall_ex(sex4),
        .flush_ex(fex4), .muldiv_done(done4), .stall_cycles(sc4));

    hazard_forward_ctrl #(.REG_ADDR_WIDTH(5), .MULDIV_LATENCY(1), .PERF_WIDTH(16)) u_dut1 (
        .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .regwrite_ex(regwrite_ex),
        .memread_ex(memread_ex), .muldiv_start_ex(muldiv_start_ex),
        .rd_mem(rd_mem), .regwrite_mem(regwrite_mem), .rd_wb(rd_wb), .regwrite_wb(regwrite_wb),
        .forwarda(fa1), .forwardb(fb1), .stall_if(sif1), .stall_id(sid1), .stall_ex(sex1),
        .flush_ex(fex1), .muldiv_done(done1), .stall_cycles(sc1));

    hazard_forward_ctrl #(.REG_ADDR_WIDTH(5), .MULDIV_LATENCY(4), .PERF_WIDTH(4)) u_dut_s (
        .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .regwrite_ex(regwrite_ex),
        .memread_ex(memread_ex), .muldiv_start_ex(muldiv_start_ex),
        .rd_mem(rd_mem), .regwrite_mem(regwrite_mem), .rd_wb(rd_wb), .regwrite_wb(regwrite_wb),
        .forwarda(fas), .forwardb(fbs), .stall_if(sifs), .stall_id(sids), .stall_ex(sexs),
        .flush_ex(fexs), .muldiv_done(dones), .stall_cycles(scs));

    // Packed as {forwarda, forwardb, stall_if, stall_id, stall_ex, flush_ex, muldiv_done}.
    assign act4 = {fa4, fb4, sif4, sid4, sex4, fex4, done4};
    assign act1 = {fa1, fb1, sif1, sid1, sex1, fex1, done1};
    assign acts = {fas, fbs, sifs, sids, sexs, fexs, dones};

    function automatic logic [1:0] fwd_ref(input logic [4:0] src);
        if (regwrite_mem && rd_mem != 0 && rd_mem == src) return 2'b10;
        if (regwrite_wb && rd_wb != 0 && rd_wb == src) return 2'b01;
        return 2'b00;
    endfunction

    // left = EX cycles still owed to an in-flight mul/div, counting the current one.
    function automatic logic [8:0] exp_ctrl(input int left, input int lat);
        logic [8:0] e;
        e = '0;
        if (!rst) return e;
        if (left > 0) begin
            e[0] = (left == 1);
            if (left > 1) e[4:2] = 3'b111;
        end else begin
            e[8:7] = fwd_ref(rs1_ex);
            e[6:5] = fwd_ref(rs2_ex);
            if (muldiv_start_ex) begin
                if (lat == 1) e[0] = 1'b1;
                else e[4:2] = 3'b111;
            end else if (memread_ex && regwrite_ex && rd_ex != 0 &&
                         ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex))) begin
                e[4] = 1'b1;
                e[3] = 1'b1;
                e[1] = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic int next_left(input int left, input int lat);
        if (left > 0) return left - 1;
        if (muldiv_start_ex && lat > 1) return lat - 1;
        return 0;
    endfunction

    task automatic model_reset();
        left4 = 0; left1 = 0; cnt16 = 0; cnt1 = 0; cnt4 = 0;
    endtask

    task automatic tick();
        logic [8:0] e4, e1;
        @(posedge clk);
        e4 = exp_ctrl(left4, 4);
        e1 = exp_ctrl(left1, 1);
        if (!rst) begin
            model_reset();
        end else begin
            if (e4[4]) begin
                if (cnt16 < 65535) cnt16++;
                if (cnt4 < 15) cnt4++;
            end
            if (e1[4] && cnt1 < 65535) cnt1++;
            left4 = next_left(left4, 4);
            left1 = next_left(left1, 1);
        end
        #1;
    endtask

    task automatic clear_inputs();
        rs1_id = 0; rs2_id = 0; rs1_ex = 0; rs2_ex = 0; rd_ex = 0; rd_mem = 0; rd_wb = 0;
        rs1_used_id = 0; rs2_used_id = 0; regwrite_ex = 0; memread_ex = 0;
        muldiv_start_ex = 0; regwrite_mem = 0; regwrite_wb = 0;
    endtask

    task automatic set_load_use();
        memread_ex = 1; regwrite_ex = 1; rd_ex = 7; rs2_id = 7; rs2_used_id = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        set_load_use();
        muldiv_start_ex = 1; rs1_ex = 5; rd_mem = 5; regwrite_mem = 1;
        #2;
        tests++;
        if (act4 !== 9'h000 || act1 !== 9'h000 || acts !== 9'h000) begin
            fails++;
            $display("FAIL reset_outputs: got %h/%h/%h required 000", act4, act1, acts);
        end
        tick();
        tests++;
        if (sc4 !== 16'd0 || sc1 !== 16'd0 || scs !== 4'd0) begin
            fails++;
            $display("FAIL reset_counters: got %0d/%0d/%0d required 0", sc4, sc1, scs);
        end
        tick();
        rst = 1'b1;
        clear_inputs();
    endtask

    task automatic test_forward();
        rs1_ex = 5; rs2_ex = 5; rd_mem = 5; regwrite_mem = 1; rd_wb = 5; regwrite_wb = 1;
        @(negedge clk);
        tests++;
        if (fa4 !== 2'b10 || fb4 !== 2'b10) begin
            fails++;
            $display("FAIL fwd_mem_priority: got %b/%b required 10/10", fa4, fb4);
        end
        tick();
        regwrite_mem = 0;
        @(negedge clk);
        tests++;
        if (fa4 !== 2'b01 || fb4 !== 2'b01) begin
            fails++;
            $display("FAIL fwd_wb: got %b/%b required 01/01", fa4, fb4);
        end
        tick();
        rs1_ex = 0; rs2_ex = 0; rd_mem = 0; rd_wb = 0; regwrite_mem = 1; regwrite_wb = 1;
        @(negedge clk);
        tests++;
        if (fa4 !== 2'b00 || fb4 !== 2'b00) begin
            fails++;
            $display("FAIL fwd_x0: got %b/%b required 00/00", fa4, fb4);
        end
        tick();
        rs1_ex = 3; rs2_ex = 9; rd_mem = 9; rd_wb = 3;
        @(negedge clk);
        tests++;
        if (fa4 !== 2'b01 || fb4 !== 2'b10) begin
            fails++;
            $display("FAIL fwd_split: got %b/%b required 01/10", fa4, fb4);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_load_use();
        set_load_use();
        @(negedge clk);
        tests++;
        if (act4 !== 9'h01A) begin
            fails++;
            $display("FAIL load_use_stall: got %h required 01a", act4);
        end
        tick();
        memread_ex = 0;
        @(negedge clk);
        tests++;
        if (act4 !== 9'h000) begin
            fails++;
            $display("FAIL load_use_release: got %h required 000", act4);
        end
        tests++;
        if (sc4 !== 16'd1) begin
            fails++;
            $display("FAIL load_use_count: got %0d required 1", sc4);
        end
        tick();
        set_load_use();
        rs2_used_id = 0;
        @(negedge clk);
        tests++;
        if (act4 !== 9'h000) begin
            fails++;
            $display("FAIL load_use_unused_src: got %h required 000", act4);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_muldiv();
        muldiv_start_ex = 1;
        memread_ex = 1; regwrite_ex = 1; rd_ex = 7; rs1_id = 7; rs1_used_id = 1;
        @(negedge clk);
        tests++;
        if (act4 !== 9'h01C) begin
            fails++;
            $display("FAIL muldiv_start: got %h required 01c", act4);
        end
        tests++;
        if (act1 !== 9'h001) begin
            fails++;
            $display("FAIL muldiv_lat1_done: got %h required 001", act1);
        end
        tick();
        tests++;
        if (sc1 !== 16'd1) begin
            fails++;
            $display("FAIL muldiv_lat1_count: got %0d required 1", sc1);
        end
        clear_inputs();
        set_load_use();
        muldiv_start_ex = 1;
        rs1_ex = 5; rd_mem = 5; regwrite_mem = 1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            tests++;
            if (act4 !== ((c < 3) ? 9'h01C : 9'h001)) begin
                fails++;
                $display("FAIL muldiv_busy_c%0d: got %h required %h", c, act4,
                         (c < 3) ? 9'h01C : 9'h001);
            end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        tests++;
        if (act4 !== 9'h000 || sc4 !== 16'd4) begin
            fails++;
            $display("FAIL muldiv_after: got %h cnt %0d required 000 cnt 4", act4, sc4);
        end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        muldiv_start_ex = 1;
        tick();
        muldiv_start_ex = 0;
        rs1_ex = 5; rd_mem = 5; regwrite_mem = 1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        #1;
        tests++;
        if (act4 !== 9'h000 || sc4 !== 16'd0 || scs !== 4'd0) begin
            fails++;
            $display("FAIL reset_mid_busy: got %h cnt %0d/%0d required 000 cnt 0", act4, sc4, scs);
        end
        tick();
        tick();
        rst = 1'b1;
        clear_inputs();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests++;
            if (act4 !== 9'h000 || sc4 !== 16'd0) begin
                fails++;
                $display("FAIL reset_release_c%0d: got %h cnt %0d required 000 cnt 0", c, act4, sc4);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        set_load_use();
        repeat (20) tick();
        @(negedge clk);
        tests++;
        if (scs !== 4'd15 || sc4 !== 16'd20) begin
            fails++;
            $display("FAIL sat_reach: got %0d/%0d required 15/20", scs, sc4);
        end
        repeat (3) tick();
        @(negedge clk);
        tests++;
        if (scs !== 4'd15 || sc4 !== 16'd23) begin
            fails++;
            $display("FAIL sat_hold: got %0d/%0d required 15/23", scs, sc4);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [8:0] e4, e1;
        for (int n = 0; n < 400; n++) begin
            rs1_id = 5'($urandom_range(0, 7));
            rs2_id = 5'($urandom_range(0, 7));
            rs1_ex = 5'($urandom_range(0, 7));
            rs2_ex = 5'($urandom_range(0, 7));
            rd_ex  = 5'($urandom_range(0, 7));
            rd_mem = 5'($urandom_range(0, 7));
            rd_wb  = 5'($urandom_range(0, 7));
            rs1_used_id     = 1'($urandom_range(0, 1));
            rs2_used_id     = 1'($urandom_range(0, 1));
            regwrite_ex     = 1'($urandom_range(0, 1));
            memread_ex      = 1'($urandom_range(0, 1));
            regwrite_mem    = 1'($urandom_range(0, 1));
            regwrite_wb     = 1'($urandom_range(0, 1));
            muldiv_start_ex = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            e4 = exp_ctrl(left4, 4);
            e1 = exp_ctrl(left1, 1);
            tests++;
            if (act4 !== e4 || acts !== e4 || act1 !== e1) begin
                fails++;
                $display("FAIL rand_ctrl_%0d: got %h/%h/%h required %h/%h/%h",
                         n, act4, acts, act1, e4, e4, e1);
            end
            tests++;
            if (sc4 !== 16'(cnt16) || scs !== 4'(cnt4) || sc1 !== 16'(cnt1)) begin
                fails++;
                $display("FAIL rand_count_%0d: got %0d/%0d/%0d required %0d/%0d/%0d",
                         n, sc4, scs, sc1, cnt16, cnt4, cnt1);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_forward();
        test_load_use();
        test_muldiv();
        test_reset_mid_busy();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
